// File: rtl/cache_mem_pkg.sv
// Shared definitions for the cache-to-main-memory arbiter: arbiter states,
// block geometry and the fill-address helper.
package cache_mem_pkg;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int BLOCK_WORDS = 8;
    localparam int MEM_LATENCY = 4;
    localparam int CNT_W       = 4;
    localparam int IDX_W       = 3;
    localparam int BLK_LSB     = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        D_WRITE = 2'd1,
        D_FILL  = 2'd2,
        I_FILL  = 2'd3
    } state_t;

    // Word k of a 16-byte block; the block number is kept as-is, so the
    // last word of block 0xFFF0 is 0xFFFE and nothing wraps to 0x0000.
    function automatic logic [ADDR_W-1:0] fillAddr(
        input logic [ADDR_W-1:BLK_LSB] blk,
        input logic [IDX_W-1:0]        k
    );
        return {blk, k, 1'b0};
    endfunction

endpackage

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I-cache and D-cache misses and D-cache write-throughs onto one
// main-memory port; fills are 8 back-to-back reads returned 4 cycles later.
module cache_mem_arbiter
    import cache_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_data_out,
    output logic              i_data_valid,
    output logic [IDX_W-1:0]  i_word_idx,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_data_in,
    output logic [DATA_W-1:0] d_data_out,
    output logic              d_data_valid,
    output logic [IDX_W-1:0]  d_word_idx,
    output logic              i_grant,
    output logic              d_grant,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_data_valid,
    output logic              busy,
    output state_t            dbgState
);

    // Handshake: a cache holds its req level until served; grant is high
    // while it owns memory; data_valid is a one-cycle strobe with no
    // back-pressure, so the cache must accept every word as it arrives.

    state_t                    state, nextState;
    logic [CNT_W-1:0]          issueCnt, retCnt;
    logic [ADDR_W-1:BLK_LSB]   blkQ;
    logic [ADDR_W-1:0]         wrAddrQ;
    logic [DATA_W-1:0]         wrDataQ;
    logic                      filling, issuing, retAccept, lastRet;

    assign filling   = (state == D_FILL) || (state == I_FILL);
    assign issuing   = filling && (issueCnt < CNT_W'(BLOCK_WORDS));
    // Returns with nothing outstanding are stale (e.g. issued before a reset).
    assign retAccept = filling && mem_data_valid && (issueCnt != retCnt);
    assign lastRet   = retAccept && (retCnt == CNT_W'(BLOCK_WORDS - 1));
    assign dbgState  = state;

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (d_req && d_wr)  nextState = D_WRITE;
                else if (d_req)     nextState = D_FILL;
                else if (i_req)     nextState = I_FILL;
            end
            D_WRITE:                nextState = IDLE;
            D_FILL, I_FILL: begin
                if (lastRet)        nextState = IDLE;
            end
            default:                nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            issueCnt <= '0;
            retCnt   <= '0;
            blkQ     <= '0;
            wrAddrQ  <= '0;
            wrDataQ  <= '0;
        end else begin
            state <= nextState;
            if (state == IDLE) begin
                issueCnt <= '0;
                retCnt   <= '0;
                if (nextState == D_WRITE) begin
                    wrAddrQ <= d_addr;
                    wrDataQ <= d_data_in;
                end
                if (nextState == D_FILL) blkQ <= d_addr[ADDR_W-1:BLK_LSB];
                if (nextState == I_FILL) blkQ <= i_addr[ADDR_W-1:BLK_LSB];
            end else begin
                if (issuing)   issueCnt <= issueCnt + 1'b1;
                if (retAccept) retCnt   <= retCnt + 1'b1;
            end
        end
    end

    always_comb begin
        mem_enable   = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_data_in  = '0;
        i_grant      = (state == I_FILL);
        d_grant      = (state == D_FILL) || (state == D_WRITE);
        busy         = (state != IDLE);
        i_data_valid = retAccept && (state == I_FILL);
        d_data_valid = retAccept && (state == D_FILL);
        i_data_out   = '0;
        d_data_out   = '0;
        i_word_idx   = '0;
        d_word_idx   = '0;
        if (state == D_WRITE) begin
            mem_enable  = 1'b1;
            mem_wr      = 1'b1;
            mem_addr    = wrAddrQ;
            mem_data_in = wrDataQ;
        end else if (issuing) begin
            mem_enable = 1'b1;
            mem_addr   = fillAddr(blkQ, issueCnt[IDX_W-1:0]);
        end
        if (i_data_valid) begin
            i_data_out = mem_data_out;
            i_word_idx = retCnt[IDX_W-1:0];
        end
        if (d_data_valid) begin
            d_data_out = mem_data_out;
            d_word_idx = retCnt[IDX_W-1:0];
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with a 4-cycle-latency memory model
// whose read data is a fixed function of the address.
module tb_cache_mem_arbiter;
    import cache_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_data_in;
    logic [15:0] i_data_out, d_data_out, mem_addr, mem_data_in, mem_data_out;
    logic        i_data_valid, d_data_valid, i_grant, d_grant;
    logic        mem_enable, mem_wr, mem_data_valid, busy;
    logic [2:0]  i_word_idx, d_word_idx;
    state_t      dbgState;

    int nCmp = 0;
    int nBad = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_data_out(i_data_out),
        .i_data_valid(i_data_valid), .i_word_idx(i_word_idx),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_data_in(d_data_in),
        .d_data_out(d_data_out), .d_data_valid(d_data_valid), .d_word_idx(d_word_idx),
        .i_grant(i_grant), .d_grant(d_grant),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_data_valid(mem_data_valid), .busy(busy), .dbgState(dbgState)
    );

    function automatic logic [15:0] memWord(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    // Memory: a read sampled at edge N returns during the cycle after edge N+3.
    logic [3:0]  pipeVld = 4'b0;
    logic [15:0] pipeAddr [4];
    always @(posedge clk) begin
        pipeVld     <= {pipeVld[2:0], mem_enable && !mem_wr};
        pipeAddr[0] <= mem_addr;
        for (int k = 1; k < 4; k++) pipeAddr[k] <= pipeAddr[k-1];
    end
    assign mem_data_valid = pipeVld[3];
    assign mem_data_out   = pipeVld[3] ? memWord(pipeAddr[3]) : 16'h0;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200us");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nBad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle c (1..12) of a fill from block base; cycle 1 is the first issue.
    task automatic checkFill(input string tag, input bit isD, input logic [15:0] base, input int c);
        logic        expEn, expVld;
        logic [15:0] expAddr, expData;
        logic [2:0]  expIdx;
        string       t;
        t       = $sformatf("%s_c%0d", tag, c);
        expEn   = (c <= 8);
        expAddr = expEn ? base + 16'(2 * (c - 1)) : 16'h0;
        expVld  = (c >= 5);
        expData = expVld ? memWord(base + 16'(2 * (c - 5))) : 16'h0;
        expIdx  = expVld ? 3'(c - 5) : 3'd0;
        chk({t, "_en"}, 32'(mem_enable), 32'(expEn));
        chk({t, "_addr"}, 32'(mem_addr), 32'(expAddr));
        chk({t, "_wr"}, 32'(mem_wr), 32'd0);
        chk({t, "_busy"}, 32'(busy), 32'd1);
        if (isD) begin
            chk({t, "_dgnt"}, 32'(d_grant), 32'd1);
            chk({t, "_ignt"}, 32'(i_grant), 32'd0);
            chk({t, "_dvld"}, 32'(d_data_valid), 32'(expVld));
            chk({t, "_ddat"}, 32'(d_data_out), 32'(expData));
            chk({t, "_didx"}, 32'(d_word_idx), 32'(expIdx));
            chk({t, "_ivld"}, 32'(i_data_valid), 32'd0);
        end else begin
            chk({t, "_ignt"}, 32'(i_grant), 32'd1);
            chk({t, "_dgnt"}, 32'(d_grant), 32'd0);
            chk({t, "_ivld"}, 32'(i_data_valid), 32'(expVld));
            chk({t, "_idat"}, 32'(i_data_out), 32'(expData));
            chk({t, "_iidx"}, 32'(i_word_idx), 32'(expIdx));
            chk({t, "_dvld"}, 32'(d_data_valid), 32'd0);
        end
    endtask

    task automatic checkIdle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_state"}, 32'(dbgState), 32'(IDLE));
        chk({tag, "_ignt"}, 32'(i_grant), 32'd0);
        chk({tag, "_dgnt"}, 32'(d_grant), 32'd0);
        chk({tag, "_en"}, 32'(mem_enable), 32'd0);
        chk({tag, "_ivld"}, 32'(i_data_valid), 32'd0);
        chk({tag, "_dvld"}, 32'(d_data_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        i_addr = 16'h0; d_addr = 16'h0; d_data_in = 16'h0;
        step(); step();
        rst = 1'b0;
        checkIdle("reset");
        chk("reset_addr", 32'(mem_addr), 32'd0);
        chk("reset_wdat", 32'(mem_data_in), 32'd0);
        chk("reset_wr", 32'(mem_wr), 32'd0);

        // I-cache fill from an unaligned address; request drops after cycle 1.
        i_req = 1'b1; i_addr = 16'h0046;
        step();
        i_req = 1'b0;
        chk("ifill_state", 32'(dbgState), 32'(I_FILL));
        checkFill("ifill", 1'b0, 16'h0040, 1);
        for (int c = 2; c <= 12; c++) begin
            step();
            checkFill("ifill", 1'b0, 16'h0040, c);
        end
        step();
        checkIdle("ifill_c13");

        // Simultaneous I and D read: D wins, I waits through the whole D fill.
        i_req = 1'b1; i_addr = 16'h0100;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h1234;
        step();
        d_req = 1'b0;
        chk("prio_state", 32'(dbgState), 32'(D_FILL));
        checkFill("prio_d", 1'b1, 16'h1230, 1);
        for (int c = 2; c <= 12; c++) begin
            step();
            checkFill("prio_d", 1'b1, 16'h1230, c);
        end
        step();
        checkIdle("prio_gap");
        step();
        i_req = 1'b0;
        chk("prio_istate", 32'(dbgState), 32'(I_FILL));
        checkFill("prio_i", 1'b0, 16'h0100, 1);
        for (int c = 2; c <= 12; c++) begin
            step();
            checkFill("prio_i", 1'b0, 16'h0100, c);
        end
        step();
        checkIdle("prio_end");

        // Write-through: one cycle on the memory port, no returned data.
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h2002; d_data_in = 16'hBEEF;
        step();
        d_req = 1'b0; d_wr = 1'b0;
        chk("wr_state", 32'(dbgState), 32'(D_WRITE));
        chk("wr_en", 32'(mem_enable), 32'd1);
        chk("wr_wr", 32'(mem_wr), 32'd1);
        chk("wr_addr", 32'(mem_addr), 32'h2002);
        chk("wr_wdat", 32'(mem_data_in), 32'hBEEF);
        chk("wr_dgnt", 32'(d_grant), 32'd1);
        chk("wr_dvld", 32'(d_data_valid), 32'd0);
        step();
        checkIdle("wr_done");
        chk("wr_done_wr", 32'(mem_wr), 32'd0);
        for (int c = 3; c <= 6; c++) begin
            step();
            chk($sformatf("wr_noret_c%0d", c), 32'(d_data_valid), 32'd0);
        end

        // Reset two cycles into a fill: the two reads in flight are dropped.
        i_req = 1'b1; i_addr = 16'h0300;
        step();
        i_req = 1'b0;
        checkFill("rstmid", 1'b0, 16'h0300, 1);
        step();
        checkFill("rstmid", 1'b0, 16'h0300, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 3; c <= 8; c++) begin
            checkIdle($sformatf("rstmid_c%0d", c));
            chk($sformatf("rstmid_c%0d_idat", c), 32'(i_data_out), 32'd0);
            chk($sformatf("rstmid_c%0d_ddat", c), 32'(d_data_out), 32'd0);
            step();
        end

        // Fill of the top block: must stop at 0xFFFE, never touch 0x0000.
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'hFFFA;
        step();
        d_req = 1'b0;
        checkFill("wrap", 1'b1, 16'hFFF0, 1);
        for (int c = 2; c <= 12; c++) begin
            step();
            checkFill("wrap", 1'b1, 16'hFFF0, c);
        end
        step();
        checkIdle("wrap_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port i_req, input, 1, I-cache miss fill request (level).
REQ-004 SHALL have port i_addr, input, 16, I-cache miss byte address.
REQ-005 SHALL have ports i_data_out (output, 16), i_data_valid (output, 1) and i_word_idx (output, 3), which carry the returned fill word and its block offset.
REQ-006 SHALL have ports d_req (input, 1), d_wr (input, 1), d_addr (input, 16) and d_data_in (input, 16), the D-cache fill or write-through request.
REQ-007 SHALL have ports d_data_out (output, 16), d_data_valid (output, 1) and d_word_idx (output, 3).
REQ-008 SHALL have ports i_grant and d_grant (output, 1 each), high while that cache owns memory.
REQ-009 SHALL have ports mem_enable, mem_wr (output, 1 each), mem_addr and mem_data_in (output, 16 each), which drive main memory.
REQ-010 SHALL have ports mem_data_out (input, 16) and mem_data_valid (input, 1), the memory read return, valid exactly 4 cycles after an enabled read.
REQ-011 SHALL have port busy, output, 1, high in any non-IDLE state.

Function
REQ-012 SHALL implement the states IDLE, D_WRITE, D_FILL and I_FILL.
REQ-013 SHALL, in IDLE, give priority d_req&d_wr > d_req > i_req, and sample the address in the transition cycle.
REQ-014 SHALL, in D_WRITE, assert mem_enable=1, mem_wr=1, mem_addr=d_addr and mem_data_in=d_data_in for exactly one cycle, then return to IDLE; no data_valid is produced.
REQ-015 SHALL, in a fill, use block base = addr & 16'hFFF0 and issue 8 reads on consecutive cycles at base+2k for k=0..7, with mem_wr=0.
REQ-016 SHALL forward each mem_data_valid word to the granted cache in the same cycle, combinationally, with word_idx equal to the return count 0..7.
REQ-017 SHALL remain in a fill until 8 words have returned (12 cycles from first issue), then go to IDLE; grant drops with the eighth valid.
REQ-018 SHALL complete a fill even if the request deasserts mid-fill; a request arriving mid-fill waits.
REQ-019 SHALL keep a 4-bit issue counter and a 4-bit return counter, and SHALL ignore mem_data_valid when the outstanding count (issue - return) is 0.
REQ-020 SHALL not carry out of the address at block 0xFFF0: last address 0xFFFE.
REQ-021 SHALL force i_data_valid and d_data_valid to 0 whenever the cache is not granted.

Reset
REQ-022 SHALL, on rst, go to IDLE, clear both counters and latched addresses, and drive all outputs to 0.
REQ-023 SHALL, after a reset mid-fill, discard the memory returns still in flight (outstanding=0) and not forward them to either cache.

Structure
REQ-024 SHALL take from shared package cache_mem_pkg: the state enum, BLOCK_WORDS=8, MEM_LATENCY=4 and ADDR_W=16.
REQ-025 SHALL be a single module; the counters are inline, with no sub-module.

Verification
REQ-026 SHALL cover: i_req=1, i_addr=0x0046 -> reads 0x0040..0x004E on cycles 1-8, i_data_valid on cycles 5-12, idx 0..7, busy low on cycle 13.
REQ-027 SHALL cover: i_req and d_req (read) in the same cycle, d_addr=0x1234 -> D_FILL from 0x1230 first, then I_FILL.
REQ-028 SHALL cover: d_req=1, d_wr=1, d_addr=0x2002, d_data_in=0xBEEF -> one cycle of mem_enable/mem_wr with 0x2002/0xBEEF, then IDLE.
REQ-029 SHALL cover: rst pulsed 2 cycles after a fill starts -> no data_valid on either cache for the next 6 cycles, state IDLE.
REQ-030 SHALL cover: fill at 0xFFFA -> addresses 0xFFF0..0xFFFE, with no access at 0x0000.
